// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Purpose:
//   Program ROM front end. It holds a DEPTH x IW program memory that is filled
//   through a load port and then read one instruction per request through a
//   fetch port. A small FSM sequences the unit through three phases:
//     LOAD : program is being written; fetches are ignored.
//     RUN  : memory is read-only; fetches return mem[P_COUNT] one cycle later.
//     HALT : entered after an HLT word (top nibble 4'b1111) is delivered; the
//            unit sits idle until a new load write arrives.
//
// Ports:
//   CLK_FT      in   1   clock, all state changes on the rising edge
//   RESET_N     in   1   asynchronous active-low reset
//   LOAD_EN     in   1   write LOAD_DATA to LOAD_ADDR this cycle
//   LOAD_ADDR   in   AW  program write address
//   LOAD_DATA   in   IW  program write data
//   LOAD_FINISH in   1   end of program load, move to RUN
//   P_COUNT     in   AW  fetch address
//   FETCH_REQ   in   1   request a fetch of mem[P_COUNT]
//   STALL       in   1   freeze all fetch-side outputs and the FSM (RUN only)
//   PROM_OUT    out  IW  registered fetched instruction
//   PROM_VALID  out  1   PROM_OUT holds a fresh instruction this cycle
//   ADDR_ERR    out  1   registered pulse: previous access was out of range
//   READY       out  1   high only while in RUN
// -----------------------------------------------------------------------------
module fetch_unit #(
   parameter int IW    = 15,
   parameter int AW    = 8,
   parameter int DEPTH = 16
) (
   input  logic          CLK_FT,
   input  logic          RESET_N,
   input  logic          LOAD_EN,
   input  logic [AW-1:0] LOAD_ADDR,
   input  logic [IW-1:0] LOAD_DATA,
   input  logic          LOAD_FINISH,
   input  logic [AW-1:0] P_COUNT,
   input  logic          FETCH_REQ,
   input  logic          STALL,
   output logic [IW-1:0] PROM_OUT,
   output logic          PROM_VALID,
   output logic          ADDR_ERR,
   output logic          READY
);

   // Index width into the memory array; DEPTH <= 2**AW so IDXW <= AW.
   localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // Depth as an AW+1 bit value so DEPTH == 2**AW still compares correctly.
   localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_next;

   logic [IW-1:0] r_prom_out;
   logic          r_prom_valid;
   logic          r_addr_err;

   logic [IW-1:0] w_prom_out_next;
   logic          w_prom_valid_next;
   logic          w_addr_err_next;

   logic          w_load_in_range;
   logic          w_fetch_in_range;
   logic          w_mem_we;
   logic [IW-1:0] w_rd_word;
   logic          w_rd_is_hlt;

   // Program store. It is deliberately left out of the reset so a program
   // survives a reset pulse; it starts out all-zero at power-up.
   logic [IW-1:0] r_mem [DEPTH] = '{default: '0};

   // -------------------------------------------------------------------------
   // Address range decode
   // -------------------------------------------------------------------------
   assign w_load_in_range  = ({1'b0, LOAD_ADDR} < LP_DEPTH);
   assign w_fetch_in_range = ({1'b0, P_COUNT}   < LP_DEPTH);

   // The word being fetched is needed before the edge so an HLT can steer the
   // FSM into HALT on the same edge that registers it into PROM_OUT. An
   // out-of-range fetch reads as zero (NOP) rather than wrapping.
   assign w_rd_word   = w_fetch_in_range ? r_mem[P_COUNT[IDXW-1:0]] : '0;
   assign w_rd_is_hlt = (w_rd_word[IW-1 -: 4] == 4'b1111);

   // -------------------------------------------------------------------------
   // Memory write port (load side only)
   // -------------------------------------------------------------------------
   always_ff @(posedge CLK_FT) begin
      if (w_mem_we) begin
         r_mem[LOAD_ADDR[IDXW-1:0]] <= LOAD_DATA;
      end
   end

   // -------------------------------------------------------------------------
   // State and output registers
   // -------------------------------------------------------------------------
   always_ff @(posedge CLK_FT or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state      <= ST_LOAD;
         r_prom_out   <= '0;
         r_prom_valid <= 1'b0;
         r_addr_err   <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_prom_out   <= w_prom_out_next;
         r_prom_valid <= w_prom_valid_next;
         r_addr_err   <= w_addr_err_next;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and next-output logic
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_next      = r_state;
      w_prom_out_next   = r_prom_out;
      w_prom_valid_next = r_prom_valid;
      w_addr_err_next   = r_addr_err;
      w_mem_we          = 1'b0;

      case (r_state)
         ST_LOAD: begin
            // STALL and FETCH_REQ have no meaning while loading.
            w_prom_valid_next = 1'b0;
            w_mem_we          = LOAD_EN & w_load_in_range;
            w_addr_err_next   = LOAD_EN & ~w_load_in_range;
            // A write in the finishing cycle still lands (w_mem_we above).
            if (LOAD_FINISH) begin
               w_state_next = ST_RUN;
            end
         end

         ST_RUN: begin
            // STALL freezes everything, including a pending ADDR_ERR, so the
            // defaults above (hold) are exactly what is wanted.
            if (!STALL) begin
               if (FETCH_REQ) begin
                  w_prom_out_next   = w_rd_word;
                  w_prom_valid_next = 1'b1;
                  w_addr_err_next   = ~w_fetch_in_range;
                  if (w_rd_is_hlt) begin
                     w_state_next = ST_HALT;
                  end
               end else begin
                  w_prom_valid_next = 1'b0;
                  w_addr_err_next   = 1'b0;
               end
            end
         end

         ST_HALT: begin
            // Only a load write wakes the unit; LOAD_FINISH alone is ignored.
            w_prom_valid_next = 1'b0;
            w_mem_we          = LOAD_EN & w_load_in_range;
            w_addr_err_next   = LOAD_EN & ~w_load_in_range;
            if (LOAD_EN) begin
               w_state_next = ST_LOAD;
            end
         end

         default: begin
            w_state_next      = ST_LOAD;
            w_prom_valid_next = 1'b0;
            w_addr_err_next   = 1'b0;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign PROM_OUT   = r_prom_out;
   assign PROM_VALID = r_prom_valid;
   assign ADDR_ERR   = r_addr_err;
   assign READY      = (r_state == ST_RUN);

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Purpose:
//   Directed plus randomized stimulus for fetch_unit, compared every cycle
//   against a behavioural model of the program ROM (an array plus a mode
//   variable) that applies the load / run / halt rules directly.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_fetch_unit;

   localparam int IW    = 15;
   localparam int AW    = 8;
   localparam int DEPTH = 16;

   localparam int M_LOAD = 0;
   localparam int M_RUN  = 1;
   localparam int M_HALT = 2;

   logic          clk_ft;
   logic          reset_n;
   logic          load_en;
   logic [AW-1:0] load_addr;
   logic [IW-1:0] load_data;
   logic          load_finish;
   logic [AW-1:0] p_count;
   logic          fetch_req;
   logic          stall;
   logic [IW-1:0] prom_out;
   logic          prom_valid;
   logic          addr_err;
   logic          ready;

   // Reference model state
   logic [IW-1:0] m_mem [DEPTH];
   int            m_mode;
   logic [IW-1:0] m_out;
   logic          m_valid;
   logic          m_err;

   int checks;
   int errors;
   int cyc;

   fetch_unit #(.IW(IW), .AW(AW), .DEPTH(DEPTH)) dut (
      .CLK_FT      (clk_ft),
      .RESET_N     (reset_n),
      .LOAD_EN     (load_en),
      .LOAD_ADDR   (load_addr),
      .LOAD_DATA   (load_data),
      .LOAD_FINISH (load_finish),
      .P_COUNT     (p_count),
      .FETCH_REQ   (fetch_req),
      .STALL       (stall),
      .PROM_OUT    (prom_out),
      .PROM_VALID  (prom_valid),
      .ADDR_ERR    (addr_err),
      .READY       (ready)
   );

   initial clk_ft = 1'b0;
   always #5 clk_ft = ~clk_ft;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".out"},   32'(prom_out),   32'(m_out));
      chk({tag, ".valid"}, 32'(prom_valid), 32'(m_valid));
      chk({tag, ".err"},   32'(addr_err),   32'(m_err));
      chk({tag, ".ready"}, 32'(ready),      32'(m_mode == M_RUN));
   endtask

   task automatic set_in(input logic le, input int la, input int ld, input logic lf,
                         input int pc, input logic fr, input logic st);
      load_en     = le;
      load_addr   = AW'(la);
      load_data   = IW'(ld);
      load_finish = lf;
      p_count     = AW'(pc);
      fetch_req   = fr;
      stall       = st;
   endtask

   // Apply one clock edge to the model from the current inputs, then compare.
   task automatic cycle(input string tag);
      int pa;
      int la;
      pa = int'(p_count);
      la = int'(load_addr);
      case (m_mode)
         M_LOAD: begin
            m_valid = 1'b0;
            m_err   = 1'b0;
            if (load_en) begin
               if (la < DEPTH) m_mem[la] = load_data;
               else            m_err = 1'b1;
            end
            if (load_finish) m_mode = M_RUN;
         end
         M_RUN: begin
            if (!stall) begin
               if (fetch_req) begin
                  m_valid = 1'b1;
                  if (pa < DEPTH) begin
                     m_out = m_mem[pa];
                     m_err = 1'b0;
                  end else begin
                     m_out = '0;
                     m_err = 1'b1;
                  end
                  if (m_out[IW-1:IW-4] == 4'b1111) m_mode = M_HALT;
               end else begin
                  m_valid = 1'b0;
                  m_err   = 1'b0;
               end
            end
         end
         default: begin
            m_valid = 1'b0;
            m_err   = 1'b0;
            if (load_en) begin
               if (la < DEPTH) m_mem[la] = load_data;
               else            m_err = 1'b1;
               m_mode = M_LOAD;
            end
         end
      endcase
      @(posedge clk_ft);
      #1;
      cyc++;
      chk_all(tag);
      $display("cyc %0d %s: le=%0b la=%0d lf=%0b pc=%0d fr=%0b st=%0b -> out=%h v=%0b err=%0b rdy=%0b",
               cyc, tag, load_en, load_addr, load_finish, p_count, fetch_req, stall,
               prom_out, prom_valid, addr_err, ready);
   endtask

   // Assert reset between clock edges and check that outputs clear at once.
   task automatic async_reset(input string tag);
      #2;
      reset_n = 1'b0;
      #1;
      m_mode  = M_LOAD;
      m_out   = '0;
      m_valid = 1'b0;
      m_err   = 1'b0;
      chk_all(tag);
      $display("async reset %s: out=%h v=%0b err=%0b rdy=%0b", tag, prom_out, prom_valid, addr_err, ready);
      reset_n = 1'b1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      cyc    = 0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_mode  = M_LOAD;
      m_out   = '0;
      m_valid = 1'b0;
      m_err   = 1'b0;

      reset_n = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0);
      #3;
      chk_all("reset");
      #1;
      reset_n = 1'b1;

      // Fetches while loading are ignored.
      set_in(0, 0, 0, 0, 2, 1, 0);
      cycle("load_fetch_ignored");

      // Load program 0x1000+i, with an out-of-range write in the middle.
      for (int i = 0; i < 15; i++) begin
         set_in(1, i, 'h1000 + i, 0, 0, 0, 0);
         cycle("load");
         if (i == 7) begin
            set_in(1, 200, 'h7fff, 0, 0, 0, 0);
            cycle("load_oob");
            chk("load_oob.err_pulse", 32'(addr_err), 32'd1);
         end
      end
      // Last write lands in the same cycle as LOAD_FINISH.
      set_in(1, 15, 'h100f, 1, 0, 0, 0);
      cycle("load_last_finish");
      chk("finish.ready", 32'(ready), 32'd1);

      set_in(0, 0, 0, 0, 3, 1, 0);
      cycle("fetch3");
      chk("fetch3.value", 32'(prom_out), 32'h1003);

      set_in(0, 0, 0, 0, 15, 1, 0);
      cycle("fetch15");
      chk("fetch15.value", 32'(prom_out), 32'h100f);

      set_in(0, 0, 0, 0, 20, 1, 0);
      cycle("fetch_oob");
      chk("fetch_oob.nop", 32'(prom_out), 32'h0);
      set_in(0, 0, 0, 0, 20, 0, 0);
      cycle("after_oob");
      chk("after_oob.err_clear", 32'(addr_err), 32'd0);

      // Stall holds the previous fetch.
      set_in(0, 0, 0, 0, 5, 1, 0);
      cycle("fetch5");
      for (int i = 0; i < 3; i++) begin
         set_in(0, 0, 0, 0, 6, 1, 1);
         cycle("stall");
         chk("stall.hold", 32'(prom_out), 32'h1005);
      end
      set_in(0, 0, 0, 0, 6, 1, 0);
      cycle("unstall");
      chk("unstall.value", 32'(prom_out), 32'h1006);

      // Load-port activity in RUN must not alter memory.
      set_in(1, 3, 'h7fff, 1, 3, 0, 0);
      cycle("run_load_ignored");
      set_in(0, 0, 0, 0, 3, 1, 0);
      cycle("fetch3_again");

      // Randomized RUN traffic (no HLT words in memory yet).
      for (int i = 0; i < 60; i++) begin
         set_in(1'($urandom_range(0, 1)), $urandom_range(0, 19), $urandom_range(0, 'h7fff),
                1'($urandom_range(0, 1)), $urandom_range(0, 19),
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0));
         cycle("rand_run");
      end

      // Reset mid-run: program survives.
      async_reset("reset_midrun");
      set_in(0, 0, 0, 1, 0, 0, 0);
      cycle("finish_after_reset");
      set_in(0, 0, 0, 0, 3, 1, 0);
      cycle("fetch3_after_reset");
      chk("survive.value", 32'(prom_out), 32'h1003);

      // HLT handling.
      async_reset("reset_for_hlt");
      set_in(1, 14, 'h7800, 0, 0, 0, 0);
      cycle("load_hlt");
      set_in(0, 0, 0, 1, 0, 0, 0);
      cycle("finish_hlt");
      set_in(0, 0, 0, 0, 14, 1, 0);
      cycle("fetch_hlt");
      chk("hlt.value", 32'(prom_out), 32'h7800);
      chk("hlt.valid", 32'(prom_valid), 32'd1);
      for (int i = 0; i < 3; i++) begin
         set_in(0, 0, 0, 0, 3, 1, i[0]);
         cycle("halted_fetch");
         chk("halted.valid", 32'(prom_valid), 32'd0);
      end
      set_in(0, 0, 0, 1, 3, 1, 0);
      cycle("halt_finish_ignored");
      chk("halt_finish.ready", 32'(ready), 32'd0);
      set_in(1, 0, 'h0001, 0, 0, 0, 0);
      cycle("halt_to_load");
      set_in(0, 0, 0, 1, 0, 0, 0);
      cycle("finish_reload");
      set_in(0, 0, 0, 0, 0, 1, 0);
      cycle("fetch0_reloaded");
      chk("reload.value", 32'(prom_out), 32'h0001);

      // Fully randomized traffic across all modes.
      for (int i = 0; i < 400; i++) begin
         set_in(1'($urandom_range(0, 3) == 0), $urandom_range(0, 19),
                ($urandom_range(0, 4) == 0) ? ('h7800 | $urandom_range(0, 'h7ff)) : $urandom_range(0, 'h77ff),
                1'($urandom_range(0, 7) == 0), $urandom_range(0, 19),
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0));
         cycle("rand_all");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
